// File: rtl/uart_cmd_pkg.sv
// Shared ASCII constants, parser/response encodings and hex helpers
// for the UART command parser (see uart_cmd_parser for UART_CMD_PARSER_ECHO_EN).
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_QM = 8'h3F;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_S  = 8'h53;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L_HI,
        ST_L_LO,
        ST_L_CR,
        ST_S_CR,
        ST_DISCARD,
        ST_RESP
    } parse_state_t;

    typedef enum logic [1:0] {
        RESP_OK,
        RESP_SW,
        RESP_ERR
    } resp_kind_t;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        logic [7:0] u;
        u = to_upper(c);
        return (u >= 8'h30 && u <= 8'h39) || (u >= 8'h41 && u <= 8'h46);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [7:0] u;
        u = to_upper(c);
        return 4'(u + ((u <= 8'h39) ? 8'h00 : 8'h09));
    endfunction

endpackage

// File: rtl/uart_cmd_resp_tx.sv
// Response buffer for the command parser: holds up to four bytes loaded
// in one cycle and streams them as an AXI-stream master.
module uart_cmd_resp_tx
    import uart_cmd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [3:0][7:0] i_data,
    input  logic [1:0]      i_last,
    output logic [7:0]      o_tdata,
    output logic            o_tvalid,
    input  logic            i_tready,
    output logic            o_done
);

    logic [3:0][7:0] r_buf;
    logic [1:0]      r_idx;
    logic [1:0]      r_last;
    logic            r_valid;
    logic            w_xfer;

    assign w_xfer   = r_valid && i_tready;
    assign o_done   = w_xfer && (r_idx == r_last);
    assign o_tvalid = r_valid;
    assign o_tdata  = r_valid ? r_buf[r_idx] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_idx   <= 2'd0;
            r_last  <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_data;
            r_idx   <= 2'd0;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            if (r_idx == r_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII line-command interpreter (Lhh / S) between UART RX and TX streams.
// Define UART_CMD_PARSER_ECHO_EN to echo every consumed byte before acting on it.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LINE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] sw,
    output logic [7:0] led,
    output logic       cmd_error
);

    localparam int CW = $clog2(MAX_LINE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LINE);

    parse_state_t    r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]      r_led, w_led_nxt;
    logic [7:0]      r_val, w_val_nxt;
    logic            r_err, w_err_nxt;
    logic            w_take, w_resp, w_load, w_tx_done, w_resp_done;
    logic [7:0]      w_byte, w_uc;
    logic            w_cr, w_lf, w_hex;
    resp_kind_t      w_kind;
    logic [3:0][7:0] w_data;
    logic [1:0]      w_last;

`ifdef UART_CMD_PARSER_ECHO_EN
    logic       r_echo_busy;
    logic [7:0] r_echo;
    logic       w_acc;

    // The echo goes out first; the byte is parsed once its echo has left.
    assign s_axis_tready = !rst && (r_state != ST_RESP) && !r_echo_busy;
    assign w_acc         = s_axis_tvalid && s_axis_tready;
    assign w_take        = r_echo_busy && w_tx_done;
    assign w_byte        = r_echo;
    assign w_resp_done   = w_tx_done && !r_echo_busy;
    assign w_load        = w_resp || w_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_busy <= 1'b0;
            r_echo      <= 8'h00;
        end else if (w_acc) begin
            r_echo_busy <= 1'b1;
            r_echo      <= s_axis_tdata;
        end else if (w_take) begin
            r_echo_busy <= 1'b0;
        end
    end
`else
    assign s_axis_tready = !rst && (r_state != ST_RESP);
    assign w_take        = s_axis_tvalid && s_axis_tready;
    assign w_byte        = s_axis_tdata;
    assign w_resp_done   = w_tx_done;
    assign w_load        = w_resp;
`endif

    assign w_uc  = to_upper(w_byte);
    assign w_cr  = (w_byte == ASCII_CR);
    assign w_lf  = (w_byte == ASCII_LF);
    assign w_hex = is_hex(w_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_led   <= 8'h00;
            r_val   <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_led   <= w_led_nxt;
            r_val   <= w_val_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_led_nxt   = r_led;
        w_val_nxt   = r_val;
        w_resp      = 1'b0;
        w_kind      = RESP_ERR;
        if (r_state == ST_RESP) begin
            if (w_resp_done) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        end else if (w_take) begin
            // Blank-line CR/LF in IDLE is not part of any line.
            if (!(r_state == ST_IDLE && (w_cr || w_lf))) begin
                w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_uc == ASCII_L) begin
                        w_state_nxt = ST_L_HI;
                    end else if (w_uc == ASCII_S) begin
                        w_state_nxt = ST_S_CR;
                    end else if (!(w_cr || w_lf)) begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_L_HI: begin
                    if (w_hex) begin
                        w_val_nxt   = {4'h0, hex_val(w_byte)};
                        w_state_nxt = ST_L_LO;
                    end else if (w_cr) begin
                        w_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_L_LO: begin
                    if (w_hex) begin
                        w_val_nxt   = {r_val[3:0], hex_val(w_byte)};
                        w_state_nxt = ST_L_CR;
                    end else if (w_cr) begin
                        w_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_L_CR: begin
                    if (w_cr) begin
                        w_resp    = 1'b1;
                        w_kind    = RESP_OK;
                        w_led_nxt = r_val;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_S_CR: begin
                    if (w_cr) begin
                        w_resp = 1'b1;
                        w_kind = RESP_SW;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    w_resp = w_cr;
                end
                default: ;
            endcase
            if (w_resp) begin
                w_state_nxt = ST_RESP;
            end else if (!w_cr && w_cnt_nxt == CNT_MAX) begin
                w_state_nxt = ST_DISCARD;
            end
        end
        w_err_nxt = w_resp && (w_kind == RESP_ERR);
    end

    always_comb begin
        w_data = '0;
        w_last = 2'd3;
        unique case (w_kind)
            RESP_OK: w_data = {ASCII_LF, ASCII_CR, ASCII_K, ASCII_O};
            RESP_SW: w_data = {ASCII_LF, ASCII_CR,
                               nib2ascii(sw[3:0]), nib2ascii(sw[7:4])};
            default: begin
                w_data = {8'h00, ASCII_LF, ASCII_CR, ASCII_QM};
                w_last = 2'd2;
            end
        endcase
`ifdef UART_CMD_PARSER_ECHO_EN
        if (w_acc) begin
            w_data = {24'h0, s_axis_tdata};
            w_last = 2'd0;
        end
`endif
    end

    uart_cmd_resp_tx u_resp_tx (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_data   (w_data),
        .i_last   (w_last),
        .o_tdata  (m_axis_tdata),
        .o_tvalid (m_axis_tvalid),
        .i_tready (m_axis_tready),
        .o_done   (w_tx_done)
    );

    assign led       = r_led;
    assign cmd_error = r_err;

endmodule
